fetch_controller: RTL and testbench

Instruction-fetch sequencer for the pipelined MIPS datapath. Owns the program counter that drives the instruction memory's `Address` input, and registers the returned `Instruction` into the IF/ID pipeline register. Handles hazard stalls, branch/jump redirects with bubble insertion, and a fault halt on out-of-range or misaligned fetch addresses. Sits between the instruction memory and the decode stage; the hazard unit and branch resolution logic drive its control inputs.

---
 rtl/fetch_controller.sv | 82 ++++++++
 tb/tb_fetch_controller.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: owns the PC, loads the IF/ID register, and handles
// stalls, redirects with a one-bubble penalty, and a sticky halt on illegal fetch.
module fetch_controller #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_WORDS = 128
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [31:0] Instruction,
  output logic [31:0] Address,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] RedirectTarget,
  output logic [31:0] IF_ID_Instruction,
  output logic [31:0] IF_ID_PCPlus4,
  output logic        IF_ID_Valid,
  output logic        AddrFault,
  output logic [31:0] FetchCount
);

  typedef enum logic [1:0] {BOOT, RUN, HALTED} state_t;

  localparam logic [29:0] WORD_LIMIT = 30'(MEM_WORDS);

  state_t      state, state_nxt;
  logic [31:0] pc;
  logic        legal;
  logic        do_redirect, do_fault, do_fetch;

  assign legal   = (pc[1:0] == 2'b00) && (pc[31:2] < WORD_LIMIT);
  assign Address = pc;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= BOOT;
    else          state <= state_nxt;
  end

  // Redirect wins over the legality check, so an illegal target faults one edge later.
  always_comb begin
    state_nxt = state;
    case (state)
      BOOT:    state_nxt = RUN;
      RUN:     if (!Redirect && !legal) state_nxt = HALTED;
      HALTED:  state_nxt = HALTED;
      default: state_nxt = BOOT;
    endcase
  end

  always_comb begin
    do_redirect = 1'b0;
    do_fault    = 1'b0;
    do_fetch    = 1'b0;
    AddrFault   = (state == HALTED);
    if (state == RUN) begin
      if (Redirect)    do_redirect = 1'b1;
      else if (!legal) do_fault    = 1'b1;
      else if (!Stall) do_fetch    = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pc                <= RESET_PC;
      IF_ID_Instruction <= '0;
      IF_ID_PCPlus4     <= '0;
      IF_ID_Valid       <= 1'b0;
      FetchCount        <= '0;
    end else if (do_redirect || do_fault) begin
      if (do_redirect) pc <= RedirectTarget;
      IF_ID_Instruction <= '0;
      IF_ID_PCPlus4     <= '0;
      IF_ID_Valid       <= 1'b0;
    end else if (do_fetch) begin
      pc                <= pc + 32'd4;
      IF_ID_Instruction <= Instruction;
      IF_ID_PCPlus4     <= pc + 32'd4;
      IF_ID_Valid       <= 1'b1;
      FetchCount        <= FetchCount + 32'd1;
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Scoreboard bench for fetch_controller: directed test-plan scenarios plus random
// stall/redirect traffic checked against a cycle-level reference model.
module tb_fetch_controller;
  localparam int          MEM_WORDS = 128;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] BAD_WORD  = 32'hDEAD_BEEF;

  logic        Clk = 1'b0, Reset_n = 1'b0, Stall = 1'b0, Redirect = 1'b0;
  logic [31:0] RedirectTarget = '0;
  logic [31:0] Instruction, Address, IF_ID_Instruction, IF_ID_PCPlus4, FetchCount;
  logic        IF_ID_Valid, AddrFault;
  logic [31:0] mem [MEM_WORDS];

  fetch_controller #(.RESET_PC(RESET_PC), .MEM_WORDS(MEM_WORDS)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Instruction(Instruction), .Address(Address),
    .Stall(Stall), .Redirect(Redirect), .RedirectTarget(RedirectTarget),
    .IF_ID_Instruction(IF_ID_Instruction), .IF_ID_PCPlus4(IF_ID_PCPlus4),
    .IF_ID_Valid(IF_ID_Valid), .AddrFault(AddrFault), .FetchCount(FetchCount)
  );

  always #5 Clk = ~Clk;

  function automatic bit is_legal(logic [31:0] a);
    return (a % 4 == 0) && (a / 4 < MEM_WORDS);
  endfunction

  function automatic logic [31:0] word_at(logic [31:0] a);
    logic [6:0] idx;
    idx = a[8:2];
    return is_legal(a) ? mem[idx] : BAD_WORD;
  endfunction

  assign Instruction = word_at(Address);

  typedef struct packed {
    logic [31:0] addr, instr, pc4, cnt;
    logic        vld, fault;
  } exp_t;

  exp_t sb[$];
  int   checks = 0, failures = 0;

  // Reference model state
  logic [31:0] m_pc, m_instr, m_pc4, m_cnt;
  bit          m_vld, m_halt, m_boot;

  task automatic check32(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = RESET_PC; m_instr = '0; m_pc4 = '0; m_cnt = '0;
    m_vld = 0; m_halt = 0; m_boot = 1;
  endtask

  task automatic model_step(bit st, bit rd, logic [31:0] tgt);
    exp_t e;
    if (m_boot) m_boot = 0;
    else if (!m_halt) begin
      if (rd) begin
        m_pc = tgt; m_instr = '0; m_pc4 = '0; m_vld = 0;
      end else if (!is_legal(m_pc)) begin
        m_halt = 1; m_instr = '0; m_pc4 = '0; m_vld = 0;
      end else if (!st) begin
        m_instr = word_at(m_pc); m_pc4 = m_pc + 4; m_vld = 1;
        m_pc = m_pc + 4; m_cnt = m_cnt + 1;
      end
    end
    e.addr = m_pc; e.instr = m_instr; e.pc4 = m_pc4; e.cnt = m_cnt;
    e.vld = m_vld; e.fault = m_halt;
    sb.push_back(e);
  endtask

  // Drive at a falling edge, predict the next rising edge, then move to the next falling edge.
  task automatic cycle(bit st, bit rd, logic [31:0] tgt);
    Stall = st; Redirect = rd; RedirectTarget = tgt;
    model_step(st, rd, tgt);
    @(negedge Clk);
  endtask

  // Asynchronous reset pulse between edges; outputs must clear before any clock edge.
  task automatic do_reset();
    #2;
    Reset_n = 1'b0;
    sb.delete();
    Stall = 0; Redirect = 0;
    #1;
    check32("rst_addr",  Address, RESET_PC);
    check32("rst_instr", IF_ID_Instruction, 32'h0);
    check32("rst_pc4",   IF_ID_PCPlus4, 32'h0);
    check32("rst_valid", {31'b0, IF_ID_Valid}, 32'h0);
    check32("rst_fault", {31'b0, AddrFault}, 32'h0);
    check32("rst_count", FetchCount, 32'h0);
    @(negedge Clk);
    Reset_n = 1'b1;
    model_reset();
  endtask

  // Monitor: compares DUT outputs with the oldest prediction after every active edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk);
      #1;
      if (Reset_n) begin
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL sb_underflow actual=empty required=entry t=%0t", $time);
        end else begin
          e = sb.pop_front();
          check32("addr",  Address, e.addr);
          check32("instr", IF_ID_Instruction, e.instr);
          check32("pc4",   IF_ID_PCPlus4, e.pc4);
          check32("valid", {31'b0, IF_ID_Valid}, {31'b0, e.vld});
          check32("fault", {31'b0, AddrFault}, {31'b0, e.fault});
          check32("count", FetchCount, e.cnt);
        end
      end
    end
  end

  initial begin
    logic [31:0] tgt;
    int          sel;
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = $urandom;
    mem[0] = 32'h2008_0001; mem[1] = 32'h2009_0002; mem[2] = 32'h0109_5020; mem[3] = 32'h0;
    model_reset();
    @(negedge Clk);
    do_reset();

    // Boot then three sequential fetches
    cycle(0, 0, 0);
    check32("boot_valid", {31'b0, IF_ID_Valid}, 32'h0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0);
    check32("tp_instr3", IF_ID_Instruction, 32'h0109_5020);
    check32("tp_pc4_3",  IF_ID_PCPlus4, 32'd12);
    check32("tp_count3", FetchCount, 32'd3);

    // Stall three cycles at PC=8
    do_reset();
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, 0);
      check32("stall_addr",  Address, 32'd8);
      check32("stall_instr", IF_ID_Instruction, 32'h2009_0002);
      check32("stall_count", FetchCount, 32'd2);
    end
    cycle(0, 0, 0);
    check32("resume_instr", IF_ID_Instruction, 32'h0109_5020);

    // Redirect overrides stall at PC=0x10
    cycle(0, 0, 0);
    check32("pre_redir_addr", Address, 32'h10);
    cycle(1, 1, 32'h40);
    check32("redir_addr",  Address, 32'h40);
    check32("redir_valid", {31'b0, IF_ID_Valid}, 32'h0);
    cycle(0, 0, 0);
    check32("redir_pc4", IF_ID_PCPlus4, 32'h44);

    // Sequential run-off past the end of memory
    cycle(0, 1, 32'h1F0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0);
    check32("runoff_addr", Address, 32'h200);
    cycle(0, 0, 0);
    check32("runoff_fault", {31'b0, AddrFault}, 32'h1);
    check32("runoff_valid", {31'b0, IF_ID_Valid}, 32'h0);
    for (int i = 0; i < 10; i++) cycle(1'($urandom_range(0, 1)), 1'(i % 2), 32'h20);
    check32("halt_addr", Address, 32'h200);

    // Misaligned redirect, then asynchronous reset clears the fault
    do_reset();
    cycle(0, 0, 0);
    cycle(0, 1, 32'h22);
    check32("mis_addr", Address, 32'h22);
    cycle(0, 0, 0);
    check32("mis_fault", {31'b0, AddrFault}, 32'h1);
    do_reset();

    // Reset mid-run at FetchCount=5, then restart from RESET_PC
    cycle(0, 0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0);
    check32("midrun_count", FetchCount, 32'd5);
    do_reset();
    cycle(0, 0, 0);
    check32("reboot_valid", {31'b0, IF_ID_Valid}, 32'h0);
    cycle(0, 0, 0);
    check32("reboot_pc4", IF_ID_PCPlus4, RESET_PC + 32'd4);

    // Random traffic
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < MEM_WORDS; i++) mem[i] = $urandom;
      do_reset();
      for (int c = 0; c < 80; c++) begin
        sel = $urandom_range(0, 9);
        if (sel < 8)       tgt = 32'($urandom_range(0, MEM_WORDS - 1)) * 4;
        else if (sel == 8) tgt = (32'($urandom_range(0, MEM_WORDS - 1)) * 4) | 32'($urandom_range(1, 3));
        else               tgt = 32'(4 * MEM_WORDS) + (32'($urandom_range(0, 64)) * 4);
        cycle(1'($urandom_range(0, 9) < 3), 1'($urandom_range(0, 19) < 2), tgt);
      end
    end

    Stall = 0; Redirect = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
